// File: rtl/i2c_pkg.sv
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared state encoding and bus constants for the I2C slave.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_WAIT_STOP = 4'd9
   } i2c_slv_state_t;

   localparam logic [6:0] I2C_GENERAL_CALL_ADDR = 7'h00;
   localparam logic [7:0] I2C_GC_RESET_CMD      = 8'h06;
   localparam logic       I2C_ACK               = 1'b0;
   localparam logic       I2C_NACK              = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
//  Module      : i2c_line_sync
//  Description : SCL/SDA synchroniser with SCL edge and START/STOP detection.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
   logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
   logic                   scl_prev_q, scl_prev_d;
   logic                   sda_prev_q, sda_prev_d;
   logic                   scl;

   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_d = scl_sync_q[SYNC_STAGES-1];
      sda_prev_d = sda_sync_q[SYNC_STAGES-1];
   end

   // Reset to the idle-bus level so leaving reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_prev_q <= scl_prev_d;
         sda_prev_q <= sda_prev_d;
      end
   end

   assign scl       = scl_sync_q[SYNC_STAGES-1];
   assign sda       = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise  =  scl & ~scl_prev_q;
   assign scl_fall  = ~scl &  scl_prev_q;
   assign start_det =  scl &  scl_prev_q &  sda_prev_q & ~sda;
   assign stop_det  =  scl &  scl_prev_q & ~sda_prev_q &  sda;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_regfile.sv
// ============================================================================
//  Module      : i2c_slave_regfile
//  Description : Oversampled I2C slave exposing an 8-bit register file.
//                Optional general-call reset: define I2C_SLV_GENERAL_CALL_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_slave_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'h2B,
   parameter int         NUM_REGS    = 16,
   parameter int         SYNC_STAGES = 2,
   localparam int        PTR_W       = $clog2(NUM_REGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scl_i,
   input  logic             sda_i,
   output logic             sda_oe,
   input  logic [PTR_W-1:0] host_addr,
   input  logic             host_we,
   input  logic [7:0]       host_wdata,
   output logic [7:0]       host_rdata,
   output logic             wr_strobe,
   output logic [PTR_W-1:0] wr_index,
   output logic [7:0]       wr_data,
   output logic             busy
);

   localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

   logic sda, scl_rise, scl_fall, start_det, stop_det;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk       (clk),
      .rst       (rst),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_slv_state_t  state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             phase_q, phase_d;
   logic             mack_q, mack_d;
   logic             gc_q, gc_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             sda_oe_q, sda_oe_d;
   logic             busy_q, busy_d;
   logic             wr_strobe_q, wr_strobe_d;
   logic [PTR_W-1:0] wr_index_q, wr_index_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic [7:0]       host_rdata_q, host_rdata_d;
   logic [7:0]       regs_q [NUM_REGS];
   logic [7:0]       regs_d [NUM_REGS];
   logic [7:0]       byte_in;
   logic [PTR_W-1:0] ptr_inc;

   // ACK states use phase: first SCL fall drives the ACK slot, second ends it.
   always_comb begin
      byte_in      = {shift_q[6:0], sda};
      ptr_inc      = ptr_q + PTR_W'(1);
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      phase_d      = phase_q;
      mack_d       = mack_q;
      gc_d         = gc_q;
      ptr_d        = ptr_q;
      sda_oe_d     = sda_oe_q;
      busy_d       = busy_q;
      wr_strobe_d  = 1'b0;
      wr_index_d   = wr_index_q;
      wr_data_d    = wr_data_q;
      host_rdata_d = regs_q[host_addr];
      regs_d       = regs_q;
      if (host_we)
         regs_d[host_addr] = host_wdata;

      if (stop_det) begin
         state_d  = ST_IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         bit_cnt_d = 3'd7;
         sda_oe_d  = 1'b0;
         gc_d      = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  phase_d = 1'b0;
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                     state_d = ST_ADDR_ACK;
                     busy_d  = 1'b1;
                  end
`ifdef I2C_SLV_GENERAL_CALL_EN
                  else if (byte_in == {I2C_GENERAL_CALL_ADDR, 1'b0}) begin
                     state_d = ST_ADDR_ACK;
                     busy_d  = 1'b1;
                     gc_d    = 1'b1;
                  end
`endif
                  else begin
                     state_d = ST_WAIT_STOP;
                  end
               end
            end
            ST_ADDR_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  sda_oe_d = ~I2C_ACK;
                  phase_d  = 1'b1;
               end else begin
                  bit_cnt_d = 3'd7;
                  if (shift_q[0]) begin
                     state_d  = ST_RDATA;
                     shift_d  = regs_q[ptr_q];
                     sda_oe_d = ~regs_q[ptr_q][7];
                  end else begin
                     state_d  = ST_PTR;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            ST_PTR: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  phase_d = 1'b0;
                  state_d = (gc_q || ({1'b0, byte_in} < NUM_REGS_W)) ? ST_PTR_ACK : ST_WAIT_STOP;
               end
            end
            ST_PTR_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  sda_oe_d = ~I2C_ACK;
                  phase_d  = 1'b1;
                  if (gc_q) begin
                     if (shift_q == I2C_GC_RESET_CMD) begin
                        regs_d = '{default: '0};
                        ptr_d  = '0;
                     end
                  end else begin
                     ptr_d = shift_q[PTR_W-1:0];
                  end
               end else begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 3'd7;
                  state_d   = gc_q ? ST_WAIT_STOP : ST_WDATA;
               end
            end
            ST_WDATA: if (scl_rise) begin
               shift_d   = byte_in;
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  regs_d[ptr_q] = byte_in;
                  wr_strobe_d   = 1'b1;
                  wr_index_d    = ptr_q;
                  wr_data_d     = byte_in;
                  state_d       = ST_WDATA_ACK;
                  phase_d       = 1'b0;
               end
            end
            ST_WDATA_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  sda_oe_d = ~I2C_ACK;
                  phase_d  = 1'b1;
               end else begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = 3'd7;
                  ptr_d     = ptr_inc;
                  state_d   = ST_WDATA;
               end
            end
            ST_RDATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  if (bit_cnt_q == 3'd0) begin
                     state_d = ST_RDATA_ACK;
                     phase_d = 1'b0;
                  end
               end else if (scl_fall) begin
                  shift_d  = {shift_q[6:0], 1'b0};
                  sda_oe_d = ~shift_q[6];
               end
            end
            ST_RDATA_ACK: begin
               if (scl_rise) begin
                  mack_d = sda;
               end else if (scl_fall) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b0;
                     phase_d  = 1'b1;
                  end else if (mack_q == I2C_ACK) begin
                     ptr_d     = ptr_inc;
                     shift_d   = regs_q[ptr_inc];
                     sda_oe_d  = ~regs_q[ptr_inc][7];
                     bit_cnt_d = 3'd7;
                     state_d   = ST_RDATA;
                  end else begin
                     sda_oe_d = 1'b0;
                     state_d  = ST_WAIT_STOP;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd7;
         shift_q      <= 8'h00;
         phase_q      <= 1'b0;
         mack_q       <= 1'b1;
         gc_q         <= 1'b0;
         ptr_q        <= '0;
         sda_oe_q     <= 1'b0;
         busy_q       <= 1'b0;
         wr_strobe_q  <= 1'b0;
         wr_index_q   <= '0;
         wr_data_q    <= 8'h00;
         host_rdata_q <= 8'h00;
         regs_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         phase_q      <= phase_d;
         mack_q       <= mack_d;
         gc_q         <= gc_d;
         ptr_q        <= ptr_d;
         sda_oe_q     <= sda_oe_d;
         busy_q       <= busy_d;
         wr_strobe_q  <= wr_strobe_d;
         wr_index_q   <= wr_index_d;
         wr_data_q    <= wr_data_d;
         host_rdata_q <= host_rdata_d;
         regs_q       <= regs_d;
      end
   end

   // Reset releases the pad immediately rather than one clock later.
   assign sda_oe     = sda_oe_q & ~rst;
   assign busy       = busy_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_index   = wr_index_q;
   assign wr_data    = wr_data_q;
   assign host_rdata = host_rdata_q;

endmodule

`default_nettype wire
